// File: rtl/arm_pipelined_flags_unit.sv
`default_nettype none
// ============================================================================
//  Module   : arm_pipelined_flags_unit
//  Purpose  : Execute-stage ALU with registered NZCV flags, update pulse/counter
//  Revision : 1.0  initial release
// ============================================================================
module arm_pipelined_flags_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Stall,
    input  logic                  i_Flush,
    input  logic                  i_Valid,
    input  logic                  i_CondEx,
    input  logic [1:0]            i_FlagWrite,
    input  logic [1:0]            i_ALUControl,
    input  logic [DATA_WIDTH-1:0] i_SrcA,
    input  logic [DATA_WIDTH-1:0] i_SrcB,
    input  logic                  i_ShifterCarry,
    output logic [DATA_WIDTH-1:0] o_ALUResult,
    output logic [1:0]            o_Flags_NZ,
    output logic [1:0]            o_Flags_CV,
    output logic                  o_FlagsUpdated,
    output logic [7:0]            o_UpdateCount
);

    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_UPDATED = 1'b1;

    logic [DATA_WIDTH-1:0] w_eff_b;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_arith;
    logic                  w_n;
    logic                  w_z;
    logic                  w_v;
    logic                  w_accept;
    logic                  w_write;

    logic [1:0] nz_q,    nz_d;
    logic [1:0] cv_q,    cv_d;
    logic [0:0] state_q, state_d;
    logic [7:0] count_q, count_d;

    // SUB is folded into the adder as A + ~B + 1
    always_comb begin
        w_arith  = ~i_ALUControl[1];
        w_eff_b  = i_ALUControl[0] ? ~i_SrcB : i_SrcB;
        w_sum    = {1'b0, i_SrcA} + {1'b0, w_eff_b}
                 + {{DATA_WIDTH{1'b0}}, i_ALUControl[0]};
        case (i_ALUControl)
            2'b10:   w_result = i_SrcA & i_SrcB;
            2'b11:   w_result = i_SrcA | i_SrcB;
            default: w_result = w_sum[DATA_WIDTH-1:0];
        endcase
        w_n = w_result[DATA_WIDTH-1];
        w_z = (w_result == '0);
        w_v = (i_SrcA[DATA_WIDTH-1] == w_eff_b[DATA_WIDTH-1])
            & (w_result[DATA_WIDTH-1] != i_SrcA[DATA_WIDTH-1]);
    end

    assign o_ALUResult = w_result;

    assign w_accept = i_Valid & i_CondEx & ~i_Stall & ~i_Flush;
    assign w_write  = w_accept & (i_FlagWrite != 2'b00);

    // Logical ops take C from the shifter and leave V untouched
    always_comb begin
        nz_d    = nz_q;
        cv_d    = cv_q;
        count_d = count_q;
        state_d = state_q;
        if (w_accept && i_FlagWrite[1]) begin
            nz_d = {w_n, w_z};
        end
        if (w_accept && i_FlagWrite[0]) begin
            if (w_arith) begin
                cv_d = {w_sum[DATA_WIDTH], w_v};
            end else begin
                cv_d[1] = i_ShifterCarry;
            end
        end
        if (w_write) begin
            count_d = count_q + 8'd1;
        end
        case (state_q)
            c_IDLE:    state_d = w_write ? c_UPDATED : c_IDLE;
            c_UPDATED: state_d = w_write ? c_UPDATED : c_IDLE;
            default:   state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            nz_q    <= 2'b00;
            cv_q    <= 2'b00;
            count_q <= 8'd0;
            state_q <= c_IDLE;
        end else begin
            nz_q    <= nz_d;
            cv_q    <= cv_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    assign o_Flags_NZ     = nz_q;
    assign o_Flags_CV     = cv_q;
    assign o_UpdateCount  = count_q;
    assign o_FlagsUpdated = (state_q == c_UPDATED);

endmodule
`default_nettype wire
